// File: rtl/morse_decoder_pkg.sv
// Shared widths, constants and the {size, data} code record used by the
// Morse character decoder and its lookup table.
package morse_decoder_pkg;

  localparam int MORSE_CHAR_WIDTH_MAX_C = 5;
  localparam int MORSE_SIZE_WIDTH_MAX_C = 3;

  // 5-symbol pattern .-.-. is not a digit, so it is free to mean word space
  localparam logic [MORSE_CHAR_WIDTH_MAX_C-1:0] MORSE_SPACE_C = 5'b01010;
  localparam logic [7:0] MORSE_ERR_ASCII_C = 8'h3F;

  typedef struct packed {
    logic [MORSE_SIZE_WIDTH_MAX_C-1:0] size;
    logic [MORSE_CHAR_WIDTH_MAX_C-1:0] data;
  } morse_code_t;

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse-to-ASCII lookup. Symbol i sits in data bit i (1 = dash),
// and data bits at or above size are ignored before the table match.
module morse_lut
  import morse_decoder_pkg::*;
(
  input  morse_code_t code,
  output logic        hit,
  output logic [7:0]  ascii
);

  logic [MORSE_CHAR_WIDTH_MAX_C-1:0] data_masked;

  generate
    for (genvar gi = 0; gi < MORSE_CHAR_WIDTH_MAX_C; gi++) begin : g_mask
      assign data_masked[gi] = code.data[gi] && (int'(code.size) > gi);
    end
  endgenerate

  always_comb begin
    hit   = 1'b1;
    ascii = 8'h00;
    case ({code.size, data_masked})
      {3'd1, 5'd0}:  ascii = 8'h45; // E
      {3'd1, 5'd1}:  ascii = 8'h54; // T
      {3'd2, 5'd0}:  ascii = 8'h49; // I
      {3'd2, 5'd1}:  ascii = 8'h4E; // N
      {3'd2, 5'd2}:  ascii = 8'h41; // A
      {3'd2, 5'd3}:  ascii = 8'h4D; // M
      {3'd3, 5'd0}:  ascii = 8'h53; // S
      {3'd3, 5'd1}:  ascii = 8'h44; // D
      {3'd3, 5'd2}:  ascii = 8'h52; // R
      {3'd3, 5'd3}:  ascii = 8'h47; // G
      {3'd3, 5'd4}:  ascii = 8'h55; // U
      {3'd3, 5'd5}:  ascii = 8'h4B; // K
      {3'd3, 5'd6}:  ascii = 8'h57; // W
      {3'd3, 5'd7}:  ascii = 8'h4F; // O
      {3'd4, 5'd0}:  ascii = 8'h48; // H
      {3'd4, 5'd1}:  ascii = 8'h42; // B
      {3'd4, 5'd2}:  ascii = 8'h4C; // L
      {3'd4, 5'd3}:  ascii = 8'h5A; // Z
      {3'd4, 5'd4}:  ascii = 8'h46; // F
      {3'd4, 5'd5}:  ascii = 8'h43; // C
      {3'd4, 5'd6}:  ascii = 8'h50; // P
      {3'd4, 5'd8}:  ascii = 8'h56; // V
      {3'd4, 5'd9}:  ascii = 8'h58; // X
      {3'd4, 5'd11}: ascii = 8'h51; // Q
      {3'd4, 5'd13}: ascii = 8'h59; // Y
      {3'd4, 5'd14}: ascii = 8'h4A; // J
      {3'd5, 5'd31}: ascii = 8'h30;
      {3'd5, 5'd30}: ascii = 8'h31;
      {3'd5, 5'd28}: ascii = 8'h32;
      {3'd5, 5'd24}: ascii = 8'h33;
      {3'd5, 5'd16}: ascii = 8'h34;
      {3'd5, 5'd0}:  ascii = 8'h35;
      {3'd5, 5'd1}:  ascii = 8'h36;
      {3'd5, 5'd3}:  ascii = 8'h37;
      {3'd5, 5'd7}:  ascii = 8'h38;
      {3'd5, 5'd15}: ascii = 8'h39;
      {3'd5, MORSE_SPACE_C}: ascii = 8'h20;
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_char_decoder.sv
// Morse character decoder: registered lookup stage feeding an ASCII FIFO with
// a valid/ready output. Define MORSE_DECODER_ERR_CHAR_EN to enqueue '?' for unknown codes.
module morse_char_decoder
  import morse_decoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_CNT_W = 8
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              s_tvalid_i,
  input  logic [MORSE_CHAR_WIDTH_MAX_C-1:0] s_tdata_i,
  input  logic [MORSE_SIZE_WIDTH_MAX_C-1:0] s_tsize_i,
  output logic                              m_tvalid_o,
  output logic [7:0]                        m_tdata_o,
  input  logic                              m_tready_i,
  output logic                              unknown_o,
  output logic [DROP_CNT_W-1:0]             drop_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  morse_code_t code;
  logic        lut_hit;
  logic [7:0]  lut_ascii;

  assign code = {s_tsize_i, s_tdata_i};

  morse_lut u_lut (
    .code  (code),
    .hit   (lut_hit),
    .ascii (lut_ascii)
  );

  logic       dec_valid_reg;
  logic [7:0] dec_ascii_reg;
  logic       unknown_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dec_valid_reg <= 1'b0;
      dec_ascii_reg <= 8'h00;
      unknown_reg   <= 1'b0;
    end else begin
`ifdef MORSE_DECODER_ERR_CHAR_EN
      dec_valid_reg <= s_tvalid_i;
      dec_ascii_reg <= lut_hit ? lut_ascii : MORSE_ERR_ASCII_C;
`else
      dec_valid_reg <= s_tvalid_i && lut_hit;
      dec_ascii_reg <= lut_ascii;
`endif
      unknown_reg   <= s_tvalid_i && !lut_hit;
    end
  end

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic [DROP_CNT_W-1:0] drop_cnt_reg;
  logic full;
  logic empty;
  logic wr_en;
  logic rd_en;

  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  // A full queue refuses the write even if the sink pops this same cycle
  assign wr_en = dec_valid_reg && !full;
  assign rd_en = !empty && m_tready_i;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= dec_ascii_reg;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      drop_cnt_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (dec_valid_reg && full && (drop_cnt_reg != '1))
        drop_cnt_reg <= drop_cnt_reg + DROP_CNT_W'(1);
    end
  end

  assign m_tvalid_o = !empty;
  assign m_tdata_o  = empty ? 8'h00 : mem[rd_ptr_reg[AW-1:0]];
  assign unknown_o  = unknown_reg;
  assign drop_cnt_o = drop_cnt_reg;

endmodule

// File: doc/morse_char_decoder.md
# morse_char_decoder

Downstream neighbour of the symbol receiver: accepts one buffered dot/dash character per input strobe, translates it to 8-bit ASCII through a registered lookup, and queues the result in a small FIFO. The FIFO presents ASCII on a valid/ready stream to the display/UART sink. Unknown codes and FIFO overflow are reported.

## Interface
- FIFO_DEPTH, 8, ASCII queue depth; power of two, ≥2
- DROP_CNT_W, 8, width of saturating dropped-character counter
- clk  input  1  clock
- resetn  input  1  synchronous active-low reset
- s_tvalid_i  input  1  single-cycle strobe: new character present
- s_tdata_i  input  MORSE_CHAR_WIDTH_MAX_C (5)  symbols; bit i = symbol i, 1 = dash, 0 = dot; first symbol in bit 0
- s_tsize_i  input  MORSE_SIZE_WIDTH_MAX_C (3)  symbol count, 1..5
- m_tvalid_o  output  1  ASCII character available
- m_tdata_o  output  8  ASCII character
- m_tready_i  input  1  sink accepts character
- unknown_o  output  1  one-cycle pulse: code not in table
- drop_cnt_o  output  DROP_CNT_W  characters lost to full FIFO, saturating

Reset is resetn, synchronous, active-low; clock is clk.

## Operation
- Stage 1 (decode): on s_tvalid_i, index the lookup with {s_tsize_i, s_tdata_i}, ignoring s_tdata_i bits ≥ s_tsize_i. Register the result and a decode-valid flag.
- Table covers A–Z (uppercase, 1–4 symbols) and 0–9 (5 symbols).
- s_tsize_i == 5 with s_tdata_i == MORSE_SPACE_C decodes to 0x20.
- s_tsize_i == 0 or 6..7, or an unlisted pattern, is unknown: unknown_o pulses in the stage-1 output cycle. Handling then depends on MORSE_DECODER_ERR_CHAR_EN.
- Stage 2 (queue): a decode-valid with a known character, or an error character, writes the FIFO if not full.
- If the FIFO is full, the character is dropped and drop_cnt_o increments, saturating at all-ones.
- A full FIFO blocks a write even when a read occurs in the same cycle; no write-through-on-read.
- FIFO: read/write pointers of log2(FIFO_DEPTH)+1 bits. Full when the MSBs differ and the remaining bits are equal; empty when the pointers are equal. Pointers wrap naturally.
- Output: m_tvalid_o = not empty; m_tdata_o = entry at the read pointer. A pop occurs when m_tvalid_o && m_tready_i.
- Once asserted, m_tvalid_o and m_tdata_o hold stable until a pop.
- Write and read in the same cycle on a non-full, non-empty FIFO both take effect; occupancy is unchanged.
- Empty FIFO plus write: no bypass. Data becomes visible on the next cycle.

## Timing
- Reset values: m_tvalid_o=0, m_tdata_o=0x00, unknown_o=0, drop_cnt_o=0. Pointers zero, stage-1 valid cleared.
- resetn low mid-operation flushes the FIFO and the in-flight stage-1 character next edge; drop_cnt_o clears.
- Strobe on cycle N: stage-1 registered at N+1 (unknown_o, if any, high during N+1); FIFO written at edge ending N+1; m_tvalid_o high at N+2 when FIFO was empty.
- Throughput: one character per cycle sustained while not full.
- Back-to-back strobes are legal; each is processed independently.

## Configuration
- MORSE_DECODER_ERR_CHAR_EN defined: unknown codes enqueue '?' (0x3F) and pulse unknown_o.
- Undefined: unknown codes pulse unknown_o only; nothing enqueued, drop_cnt_o unaffected.

## Structure
- morse_decoder_pkg holds:
  - MORSE_CHAR_WIDTH_MAX_C, MORSE_SIZE_WIDTH_MAX_C
  - MORSE_SPACE_C, with a value that collides with no digit code
  - MORSE_ERR_ASCII_C = 8'h3F
  - a morse_code_t struct {size, data}
- Sub-module morse_lut: purely combinational {size,data} → {hit, ascii}, case-based. Registered by the parent.
- FIFO stays inline in the parent; no separate module.

## Test plan
- Strobe data=5'b00010, size=2 ('A' .-) with m_tready_i=1 -> m_tvalid_o at N+2, m_tdata_o=0x41, popped next cycle; FIFO empty.
- Strobe size=5 data=MORSE_SPACE_C, then size=5 data=5'b11110 ('1') -> 0x20 then 0x31 in order.
- Strobe size=4 data=5'b01111 (----, unlisted) -> unknown_o pulse at N+1. With ERR_EN: 0x3F output. Without: no m_tvalid_o.
- m_tready_i=0, 10 strobes of 'E' (size=1, data=0) -> first 8 stored, drop_cnt_o=2. Then ready=1 -> exactly 8 × 0x45 out.
- Full FIFO, simultaneous pop and strobe -> strobe dropped (drop_cnt_o+1), occupancy becomes 7.
- resetn low while FIFO holds 3 chars and a strobe is in stage 1 -> next cycle m_tvalid_o=0, drop_cnt_o=0; no stale output after release.
